// File: rtl/s2p_tx_sched.sv
// s2p_tx_sched: round-robin transmit scheduler for the serial-to-parallel link.
// Picks one byte requester at a time, shifts the byte out MSB-first on
// wra_n/da, then holds wra_n high for GAP extra cycles so the receiver on the
// far clock domain can resynchronise and capture the byte before the next frame.
module s2p_tx_sched #(
  parameter int N_REQ = 4,
  parameter int GAP   = 4
) (
  input  logic                     clka,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     wra_n,
  output logic                     da,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] gnt_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            win_found;
  logic [7:0]      win_byte;
  logic            accept;
  // Bit 7 of the byte goes straight into the da register on accept, so only
  // the remaining seven bits need to be held for shifting.
  logic [6:0]      shreg_q;
  logic [2:0]      bit_cnt_q;
  logic [GW-1:0]   gap_cnt_q;
  logic            wra_n_nxt;
  logic            da_nxt;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_byte = req_data[8*win_idx +: 8];
  assign accept   = |(req_valid & req_ready);

  // State register together with the registered serial outputs and busy.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      wra_n   <= 1'b1;
      da      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy    <= (state_nxt != ST_IDLE);
      wra_n   <= wra_n_nxt;
      da      <= da_nxt;
    end
  end

  // Next-state decode: IDLE -> SHIFT on accept, 8 bits, then GAP cycles.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt_q == 3'd7) state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt_q == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: ready only in IDLE (and never under reset), plus the
  // values wra_n/da take in the next cycle.
  always_comb begin
    req_ready = '0;
    wra_n_nxt = 1'b1;
    da_nxt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rstn && win_found) req_ready = N_REQ'(1) << win_idx;
        if (accept) begin
          wra_n_nxt = 1'b0;
          da_nxt    = win_byte[7];
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q != 3'd7) begin
          wra_n_nxt = 1'b0;
          da_nxt    = shreg_q[6];
        end
      end
      default: ;
    endcase
  end

  // Shift register, bit/gap counters and arbitration pointer.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      gnt_id    <= '0;
      last_q    <= LAST_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shreg_q   <= win_byte[6:0];
            bit_cnt_q <= '0;
            gnt_id    <= win_idx;
            last_q    <= win_idx;
          end
        end
        ST_SHIFT: begin
          shreg_q   <= {shreg_q[5:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) gap_cnt_q <= '0;
        end
        ST_GAP: begin
          gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_tx_sched.sv
// Directed bench for s2p_tx_sched: default build (GAP=4) plus a GAP=1 build.
module tb_s2p_tx_sched;

  logic        clka = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wra_n, da, busy;
  logic [1:0]  gnt_id;

  logic [3:0]  v1;
  logic [31:0] d1;
  logic [3:0]  rdy1;
  logic        wra1, da1, busy1;
  logic [1:0]  gid1;

  int nchk = 0;
  int nerr = 0;

  // Downstream receiver model: shifts while wra_n low, counts wra_n rising edges.
  logic [7:0] rx_sr;
  logic       wra_q;
  int         nfr;

  always #5 clka = ~clka;

  s2p_tx_sched #(.N_REQ(4), .GAP(4)) dut (
    .clka(clka), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wra_n(wra_n), .da(da), .busy(busy), .gnt_id(gnt_id)
  );

  s2p_tx_sched #(.N_REQ(4), .GAP(1)) dut1 (
    .clka(clka), .rstn(rstn), .req_valid(v1), .req_data(d1),
    .req_ready(rdy1), .wra_n(wra1), .da(da1), .busy(busy1), .gnt_id(gid1)
  );

  always @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      rx_sr <= 8'h00;
      wra_q <= 1'b1;
      nfr   <= 0;
    end else begin
      wra_q <= wra_n;
      if (!wra_n) rx_sr <= {rx_sr[6:0], da};
      if (wra_n && !wra_q) nfr <= nfr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge clka);
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 4'b0000;
    mid();
    rstn = 1'b0;
    step();
    mid();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] bytes [4];
    logic [3:0] rdy_or;
    int hi;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;

    // Reset state, with a request already pending
    rstn      = 1'b0;
    req_valid = 4'b0001;
    req_data  = 32'h000000A5;
    v1        = 4'b0000;
    d1        = 32'h0;
    step(); step();
    mid();
    chk("rst_wra_n", wra_n, 1);
    chk("rst_da", da, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_ready_gated", req_ready, 0);
    step();

    // Single byte 0xA5 from requester 0
    rstn = 1'b1;
    mid();
    chk("single_ready", req_ready, 4'b0001);
    chk("single_busy_idle", busy, 0);
    step();
    req_valid = 4'b0000;
    b = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("single_wra_low", wra_n, 0);
      chk("single_da", da, b[7-i]);
      if (i == 0) begin
        chk("single_busy_rise", busy, 1);
        chk("single_gnt_id", gnt_id, 0);
      end
      step();
    end
    for (int j = 0; j < 4; j++) begin
      mid();
      chk("single_gap_wra", wra_n, 1);
      chk("single_gap_busy", busy, 1);
      step();
    end
    mid();
    chk("single_idle_busy", busy, 0);
    chk("single_idle_wra", wra_n, 1);
    chk("single_rx_byte", rx_sr, 8'hA5);
    chk("single_rx_frames", nfr, 1);
    step();

    // All four requesters continuously valid
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk("rr_ready", req_ready, 32'(1) << (k % 4));
      if (k > 0) chk("rr_rx_byte", rx_sr, bytes[(k - 1) % 4]);
      step();
      rdy_or = 4'b0000;
      for (int j = 1; j <= 12; j++) begin
        mid();
        if (j == 1) chk("rr_gnt_id", gnt_id, k % 4);
        if (j >= 9) chk("rr_gap_wra", wra_n, 1);
        rdy_or = rdy_or | req_ready;
        step();
      end
      chk("rr_no_ready_in_frame", rdy_or, 0);
    end

    // Rotation pointer: 2 alone, then 2 and 3 together
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h44332211;
    mid();
    chk("rot_first_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    for (int j = 1; j <= 12; j++) step();
    req_valid = 4'b1100;
    mid();
    chk("rot_grant3", req_ready, 4'b1000);
    step();
    req_valid = 4'b0100;
    for (int j = 1; j <= 12; j++) step();
    mid();
    chk("rot_grant2", req_ready, 4'b0100);
    step();
    mid();
    chk("rot_gnt_id", gnt_id, 2);
    req_valid = 4'b0000;
    step();

    // Late request from 1 during bit 3 of a requester-0 frame
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h00005AC3;
    mid();
    chk("late_r0_ready", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    b = 8'hC3;
    rdy_or = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) req_valid = 4'b0010;
      mid();
      chk("late_r0_da", da, b[7-i]);
      chk("late_r0_wra", wra_n, 0);
      rdy_or = rdy_or | req_ready;
      step();
    end
    for (int j = 0; j < 4; j++) begin
      mid();
      rdy_or = rdy_or | req_ready;
      step();
    end
    chk("late_ready_held_off", rdy_or, 0);
    mid();
    chk("late_r1_ready", req_ready, 4'b0010);
    chk("late_rx_byte", rx_sr, 8'hC3);
    step();
    mid();
    chk("late_gnt_id", gnt_id, 1);
    step();
    req_valid = 4'b0000;

    // Reset during bit 4 of the requester-1 frame
    step(); step();
    #2;
    chk("mid_pre_wra", wra_n, 0);
    req_valid = 4'b1001;
    rstn = 1'b0;
    #1;
    chk("mid_rst_wra", wra_n, 1);
    chk("mid_rst_da", da, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    mid();
    rstn = 1'b1;
    #1;
    chk("mid_rel_ready", req_ready, 4'b0001);
    step();
    mid();
    chk("mid_rel_gnt_id", gnt_id, 0);
    chk("mid_rel_busy", busy, 1);
    req_valid = 4'b0000;
    step();

    // GAP=1 build with continuous requests
    v1 = 4'b1111;
    d1 = 32'h44332211;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("g1_ready", rdy1, 32'(1) << k);
      if (k > 0) chk("g1_wra_at_accept", wra1, 1);
      step();
      hi = 0;
      rdy_or = 4'b0000;
      for (int j = 1; j <= 9; j++) begin
        mid();
        if (wra1) hi++;
        rdy_or = rdy_or | rdy1;
        step();
      end
      chk("g1_gap_high_cycles", hi, 1);
      chk("g1_no_ready_in_frame", rdy_or, 0);
    end
    v1 = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/s2p_tx_sched.md
# s2p_tx_sched

Transmit-side scheduler for the serial-to-parallel link. It arbitrates up to N_REQ byte requesters round-robin and serializes each granted byte MSB-first onto the `wra_n`/`da` serial interface in the `clka` domain. It guarantees the inter-frame gap that the `clkb`-side receiver needs to synchronize `wra_n`, detect its rising edge and capture the byte before the next frame overwrites the shift register.

## Interface
- N_REQ, 4: number of requesters, ≥2.
- GAP, 4: minimum extra cycles `wra_n` stays high after a frame, ≥1.

Ports:
- clka  in  1  single clock; all logic is on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  requester i has a byte pending.
- req_data  in  8*N_REQ  byte of requester i is at [8i+7:8i].
- req_ready  out  N_REQ  one-hot; the byte is accepted when `req_valid[i] & req_ready[i]`.
- wra_n  out  1  serial frame enable, active low, registered.
- da  out  1  serial data, MSB first, registered.
- busy  out  1  high whenever the FSM is not in IDLE.
- gnt_id  out  $clog2(N_REQ)  index of the last accepted requester.

## Operation
- FSM states: IDLE, SHIFT, GAP. Reset state is IDLE.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from (last+1) mod N_REQ upward with wrap-around.
  - `req_ready` is combinational: the one-hot winner in IDLE, and 0 in every other state.
  - On accept:
    - Load `req_data[winner]` into an 8-bit shift register.
    - Set `gnt_id` and `last` to winner.
    - Clear the bit counter and go to SHIFT.
- SHIFT:
  - `wra_n`=0 and `da`=shreg[7] for each of 8 cycles; shreg shifts left by 1 each cycle.
  - The 3-bit counter counts 0..7. On 7, go to GAP.
- GAP: `wra_n`=1, `da`=0. Count GAP cycles, then go to IDLE.
- In IDLE: `wra_n`=1, `da`=0.
- Requests are sampled only in IDLE. Requesters must hold valid and data until ready. A valid dropped before ready is simply not served.
- `last` resets to N_REQ-1, so requester 0 wins first after reset.
- Priority rotation: requester (last+1) mod N_REQ has the highest priority; `last` has the lowest.
- An invalid-free IDLE holds `last`.

## Timing
- Accept in cycle T (IDLE).
- T+1..T+8: `wra_n`=0; `da` carries bits 7,6,…,0 in order.
- T+9..T+8+GAP: GAP state, `wra_n`=1.
- T+9+GAP: IDLE; the earliest next accept.
- Back-to-back accept period is 9+GAP cycles (13 at GAP=4). `wra_n` is high for at least GAP+1 cycles between frames.
- After the last bit, the downstream receiver shift register holds the byte with bit 7 in its MSB. It stays unchanged until the next frame starts, at least GAP+1 `clka` cycles later.
- `busy` = (state != IDLE) and is registered with the state. It rises at T+1 and falls at T+9+GAP.
- Reset values:
  - State: IDLE.
  - `wra_n`=1, `da`=0, `busy`=0, `gnt_id`=0, `last`=N_REQ-1.
  - `req_ready`=0 while rstn is low (gated by rstn).
  - Shift register and counter: 0.
- Reset mid-frame: `wra_n` goes to 1 and `da` to 0 asynchronously. The partial frame is abandoned and not retried. After release, arbitration restarts with requester 0 first.
- Simultaneous valids: exactly one ready bit per accept cycle. A valid arriving in SHIFT or GAP waits until IDLE.

## Test plan
- **Single byte.** Reset, then `req_valid[0]`=1 with `req_data[7:0]`=0xA5.
  - Required: `req_ready[0]` high for 1 cycle.
  - Next 8 cycles: `wra_n`=0 and `da`=1,0,1,0,0,1,0,1.
  - Then `wra_n`=1 for ≥5 cycles.
  - A downstream s2p yields `db`=0xA5 and one `wrb` pulse.
- **All requesters busy.** All four valid continuously with bytes 0x11, 0x22, 0x33, 0x44.
  - Required: grants 0,1,2,3,0,…; `gnt_id` follows.
  - Accepts exactly 13 cycles apart; no frame overlap.
- **Rotation pointer.** Only requester 2 valid, served; then requesters 2 and 3 valid together.
  - Required: grant 3 first, then 2.
- **Late request.** `req_valid[1]` asserted during bit 3 of a requester-0 frame.
  - Required: `req_ready[1]`=0 until IDLE, accepted at T+9+GAP.
  - The requester-0 serial stream is unaffected.
- **Reset mid-frame.** Assert rstn low during bit 4 of a frame.
  - Required: `wra_n`=1, `da`=0, `busy`=0 immediately.
  - After release, with requesters 0 and 3 valid, requester 0 is granted first.
- **GAP=1 build.** Continuous requests.
  - Required: accept period 10 cycles.
  - `wra_n` high exactly 2 cycles between frames.
